counter_checker: RTL and testbench

//  Cycle-accurate shadow model and checker for the team's up/down preload counter.

---
 rtl/counter_checker.sv | 135 +++++++++++++
 tb/tb_counter_checker.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// Shadow model and checker for the up/down preload counter: tracks the counter's
// inputs each edge, compares its registered outputs and reports divergence.
module counter_checker #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             check_en,
  input  logic             clear_err,
  input  logic             cnt_enable,
  input  logic             cnt_preload,
  input  logic [WIDTH-1:0] cnt_pdata,
  input  logic             cnt_mode,
  input  logic [WIDTH-1:0] cnt_result,
  input  logic             cnt_detect,
  output logic             mismatch,
  output logic             error,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_got,
  output logic             synced
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FAIL  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = ERR_W'(1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] model_reg, model_next, model_base;
  logic             model_det_reg, model_det_next;
  logic             hit, comparing, record;

  logic             mismatch_reg, mismatch_next;
  logic             error_reg, error_next;
  logic [ERR_W-1:0] err_count_reg, err_count_next;
  logic [WIDTH-1:0] first_exp_reg, first_exp_next;
  logic [WIDTH-1:0] first_got_reg, first_got_next;

  // On clear the model resyncs by stepping from the observed result instead of itself.
  assign model_base = clear_err ? cnt_result : model_reg;

  always_comb begin
    model_next     = model_base;
    model_det_next = cnt_enable & ~cnt_preload & (model_base == CNT_MAX);
    if (cnt_enable) begin
      if (cnt_preload)   model_next = cnt_pdata;
      else if (cnt_mode) model_next = model_base - CNT_ONE;
      else               model_next = model_base + CNT_ONE;
    end
  end

  assign hit       = (cnt_result != model_reg) | (cnt_detect != model_det_reg);
  assign comparing = (state_reg == CHECK) | (state_reg == FAIL);
  assign record    = comparing & hit & ~clear_err;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    if (clear_err) begin
      state_next = check_en ? CHECK : IDLE;
    end else begin
      case (state_reg)
        IDLE:    state_next = check_en ? CHECK : IDLE;
        CHECK:   state_next = !check_en ? IDLE : (hit ? FAIL : CHECK);
        FAIL:    state_next = check_en ? FAIL : IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output logic; first_* only capture while no error is outstanding
  always_comb begin
    mismatch_next  = 1'b0;
    error_next     = error_reg;
    err_count_next = err_count_reg;
    first_exp_next = first_exp_reg;
    first_got_next = first_got_reg;
    if (clear_err) begin
      error_next     = 1'b0;
      err_count_next = '0;
      first_exp_next = '0;
      first_got_next = '0;
    end else if (record) begin
      mismatch_next = 1'b1;
      error_next    = 1'b1;
      if (err_count_reg != ERR_MAX) err_count_next = err_count_reg + ERR_ONE;
      if (!error_reg) begin
        first_exp_next = model_reg;
        first_got_next = cnt_result;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      model_reg     <= '0;
      model_det_reg <= 1'b0;
      mismatch_reg  <= 1'b0;
      error_reg     <= 1'b0;
      err_count_reg <= '0;
      first_exp_reg <= '0;
      first_got_reg <= '0;
    end else begin
      model_reg     <= model_next;
      model_det_reg <= model_det_next;
      mismatch_reg  <= mismatch_next;
      error_reg     <= error_next;
      err_count_reg <= err_count_next;
      first_exp_reg <= first_exp_next;
      first_got_reg <= first_got_next;
    end
  end

  assign mismatch  = mismatch_reg;
  assign error     = error_reg;
  assign err_count = err_count_reg;
  assign first_exp = first_exp_reg;
  assign first_got = first_got_reg;
  assign synced    = (state_reg != IDLE);

endmodule

// File: tb/tb_counter_checker.sv
// Scoreboard bench: a behavioural counter drives the checker (with injectable faults)
// and a behavioural checker model predicts every registered output.
module tb_counter_checker;

  logic       clk = 1'b0;
  logic       reset, check_en, clear_err;
  logic       cnt_enable, cnt_preload, cnt_mode, cnt_detect;
  logic [3:0] cnt_pdata, cnt_result;
  logic       mismatch, error, synced;
  logic [7:0] err_count;
  logic [3:0] first_exp, first_got;

  counter_checker #(.WIDTH(4), .ERR_W(8)) dut (
    .clk(clk), .reset(reset), .check_en(check_en), .clear_err(clear_err),
    .cnt_enable(cnt_enable), .cnt_preload(cnt_preload), .cnt_pdata(cnt_pdata),
    .cnt_mode(cnt_mode), .cnt_result(cnt_result), .cnt_detect(cnt_detect),
    .mismatch(mismatch), .error(error), .err_count(err_count),
    .first_exp(first_exp), .first_got(first_got), .synced(synced)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mis;
    logic       err;
    logic [7:0] cnt;
    logic [3:0] fe;
    logic [3:0] fg;
    logic       syn;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Stimulus counter (the device being watched) and fault injection
  int   ctr = 0, cdet = 0;
  logic [3:0] xmask = 4'h0;
  logic       det_flip = 1'b0;

  // Reference checker state
  int   m = 0, mdet = 0, armed = 0, r_err = 0, r_cnt = 0, r_fe = 0, r_fg = 0, r_mis = 0;

  function automatic int step(input int v, input int en, input int pre, input int pd,
                              input int md);
    if (!en) return v;
    if (pre) return pd;
    return md ? (v + 15) % 16 : (v + 1) % 16;
  endfunction

  task automatic model_reset();
    m = 0; mdet = 0; armed = 0; r_err = 0; r_cnt = 0; r_fe = 0; r_fg = 0; r_mis = 0;
    ctr = 0; cdet = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.mis = r_mis[0]; e.err = r_err[0]; e.cnt = 8'(r_cnt);
    e.fe = 4'(r_fe); e.fg = 4'(r_fg); e.syn = armed[0];
    return e;
  endfunction

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // One clock: drive observed counter outputs, predict the edge, advance the counter.
  task automatic cycle();
    int res, det, hit, base, en, pre;
    res = ctr ^ int'(xmask);
    det = cdet ^ int'(det_flip);
    cnt_result = 4'(res);
    cnt_detect = det[0];
    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      en  = int'(cnt_enable);
      pre = int'(cnt_preload);
      hit = armed && (res != m || det != mdet);
      if (clear_err) begin
        r_err = 0; r_cnt = 0; r_fe = 0; r_fg = 0; r_mis = 0;
        base = res;
      end else begin
        r_mis = hit;
        if (hit) begin
          if (!r_err) begin r_fe = m; r_fg = res; end
          r_err = 1;
          if (r_cnt < 255) r_cnt = r_cnt + 1;
        end
        base = m;
      end
      armed = int'(check_en);
      m     = step(base, en, pre, int'(cnt_pdata), int'(cnt_mode));
      mdet  = en && !pre && base == 15;
      cdet  = en && !pre && ctr == 15;
      ctr   = step(ctr, en, pre, int'(cnt_pdata), int'(cnt_mode));
    end
    q.push_back(model_out());
    @(negedge clk);
  endtask

  // Monitor: one comparison per registered output snapshot
  initial begin
    exp_t e, g;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        g = '{mismatch, error, err_count, first_exp, first_got, synced};
        vectors++;
        if (g !== e) begin
          miscompares++;
          $display("FAIL vec%0d: got mis=%b err=%b cnt=%h fe=%h fg=%h syn=%b expected mis=%b err=%b cnt=%h fe=%h fg=%h syn=%b",
                   vectors, g.mis, g.err, g.cnt, g.fe, g.fg, g.syn,
                   e.mis, e.err, e.cnt, e.fe, e.fg, e.syn);
        end else begin
          $display("vec%0d ok: mis=%b err=%b cnt=%h fe=%h fg=%h syn=%b",
                   vectors, g.mis, g.err, g.cnt, g.fe, g.fg, g.syn);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_zero(input string name);
    check({name, "_mismatch"}, int'(mismatch), 0);
    check({name, "_error"}, int'(error), 0);
    check({name, "_err_count"}, int'(err_count), 0);
    check({name, "_first_exp"}, int'(first_exp), 0);
    check({name, "_first_got"}, int'(first_got), 0);
    check({name, "_synced"}, int'(synced), 0);
  endtask

  initial begin
    reset = 1'b1; check_en = 1'b0; clear_err = 1'b0;
    cnt_enable = 1'b0; cnt_preload = 1'b0; cnt_pdata = 4'h0; cnt_mode = 1'b0;
    cnt_result = 4'h0; cnt_detect = 1'b0;
    #1;
    check_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // Free-running up count through the 15->0 wrap
    check_en = 1'b1; cnt_enable = 1'b1; cnt_mode = 1'b0;
    for (int i = 0; i < 20; i++) cycle();

    // Preload 3 then count down through 0 -> F
    cnt_preload = 1'b1; cnt_pdata = 4'h3; cnt_mode = 1'b1;
    cycle();
    cnt_preload = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    check("down_wrap_result", ctr, 15);

    // Single forced 9 while the model holds 7
    cnt_mode = 1'b0;
    for (int i = 0; i < 16 && ctr != 7; i++) cycle();
    check("reach_seven", ctr, 7);
    xmask = 4'h7 ^ 4'h9;
    cycle();
    xmask = 4'h0;
    check("first_exp", int'(first_exp), 7);
    check("first_got", int'(first_got), 9);
    check("err_count_one", int'(err_count), 1);
    cycle();

    // Persistent divergence saturates the counter
    xmask = 4'h5;
    for (int i = 0; i < 300; i++) cycle();
    xmask = 4'h0;
    check("err_sat", int'(err_count), 255);
    check("first_exp_frozen", int'(first_exp), 7);

    // Clear while observing A in up mode: model resyncs to B
    ctr = 10; cdet = 0; cnt_enable = 1'b1; cnt_mode = 1'b0; cnt_preload = 1'b0;
    clear_err = 1'b1;
    cycle();
    clear_err = 1'b0;
    for (int i = 0; i < 3; i++) cycle();

    // Re-enter FAIL, then asynchronous reset in mid-cycle
    xmask = 4'h1;
    cycle();
    xmask = 4'h0;
    cycle();
    #2 reset = 1'b1;
    model_reset();
    #1;
    check_zero("async_reset");
    cycle();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) cycle();

    // Randomized traffic with occasional faults, clears and disarms
    for (int i = 0; i < 400; i++) begin
      check_en    = ($urandom % 16) != 0;
      clear_err   = ($urandom % 20) == 0;
      cnt_enable  = ($urandom % 4) != 0;
      cnt_preload = ($urandom % 8) == 0;
      cnt_pdata   = 4'($urandom);
      cnt_mode    = 1'($urandom);
      xmask       = (($urandom % 10) == 0) ? 4'($urandom) : 4'h0;
      det_flip    = ($urandom % 25) == 0;
      cycle();
    end
    clear_err = 1'b0; xmask = 4'h0; det_flip = 1'b0;
    cycle();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
